tff_counter_ctrl: RTL and testbench

- Sequencer for a bank of WIDTH toggle (T-type) flip-flops that together form a loadable up/down counter.
- Each cycle the controller computes the per-bit toggle vector: a one-cycle parallel load (t = q XOR value), then stepped counting toward a target, then a one-cycle done pulse.
- Sits between a host issuing start/load/target commands and the toggle-flop bank; the bank is instantiated inside this block.

---
 rtl/tff_counter_ctrl_pkg.sv | 31 +++
 rtl/tff_counter_ctrl_if.sv | 23 ++
 rtl/tff_counter_ctrl_bank.sv | 21 ++
 rtl/tff_counter_ctrl.sv | 78 +++++++
 tb/tb_tff_counter_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/tff_counter_ctrl_pkg.sv
// Shared types and helpers for the toggle-flop counter sequencer.
package tff_counter_ctrl_pkg;

  // Widest bank supported by the shared toggle helper.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Toggle vector that advances a WIDTH-bit counter by one step.
  // Up: bit i toggles when all lower bits are 1; down: when all lower bits are 0.
  // Bits at or above 'width' are returned as zero.
  function automatic logic [MAX_W-1:0] step_toggle(input logic [MAX_W-1:0] q,
                                                   input int width,
                                                   input logic up);
    logic [MAX_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (int'(i) < width) begin
        if (i == 0) t[i] = 1'b1;
        else        t[i] = t[i-1] & (up ? q[i-1] : ~q[i-1]);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/tff_counter_ctrl_if.sv
// Host-side command/status bundle for the toggle-flop counter sequencer.
interface tff_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] target;
  logic             up;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] t_vec;

  modport master (
    output start, load_val, target, up,
    input  busy, done, count, t_vec
  );

  modport slave (
    input  start, load_val, target, up,
    output busy, done, count, t_vec
  );
endinterface

// File: rtl/tff_counter_ctrl_bank.sv
// Bank of T flip-flops: each bit flips when its toggle input is high.
module tff_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Toggle state on every rising edge; clr forces all flops to zero.
  always_ff @(posedge clk) begin
    if (clr) r_q <= '0;
    else     r_q <= r_q ^ t;
  end

  assign q = r_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Sequencer driving a T-flop bank as a loadable up/down counter:
// one-cycle parallel load, step toward target, one-cycle done pulse.
module tff_counter_ctrl
  import tff_counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  tff_counter_ctrl_if.slave bus
);

  typedef logic [WIDTH-1:0] cnt_t;

  state_t r_state;
  state_t w_state_next;
  cnt_t   r_load;
  cnt_t   r_target;
  logic   r_up;
  cnt_t   w_q;
  cnt_t   w_t;
  cnt_t   w_step;

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .clr (clr),
    .t   (w_t),
    .q   (w_q)
  );

  assign w_step = cnt_t'(step_toggle(MAX_W'(w_q), WIDTH, r_up));

  // State register and command capture; commands are only accepted in IDLE.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_load   <= '0;
      r_target <= '0;
      r_up     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && bus.start) begin
        r_load   <= bus.load_val;
        r_target <= bus.target;
        r_up     <= bus.up;
      end
    end
  end

  // Next-state and per-cycle toggle vector for the bank.
  always_comb begin
    w_state_next = r_state;
    w_t          = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_t          = w_q ^ r_load;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_q == r_target) w_state_next = ST_DONE;
        else                 w_t = w_step;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.busy  = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign bus.done  = (r_state == ST_DONE);
  assign bus.count = w_q;
  assign bus.t_vec = w_t;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Scoreboard bench for tff_counter_ctrl: the stimulus side pushes one expected
// snapshot per cycle for each command, the monitor pops and compares on negedge.
module tb_tff_counter_ctrl;
  import tff_counter_ctrl_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic         busy;
    logic         done;
    logic [W-1:0] count;
    logic [W-1:0] tvec;
  } exp_t;

  logic   clk = 1'b0;
  logic   clr;
  exp_t   sb[$];
  int     n_pass  = 0;
  int     n_total = 0;
  logic [W-1:0] mq = '0;

  tff_counter_ctrl_if #(.WIDTH(W)) bus ();

  tff_counter_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic b, input logic d,
                              input logic [W-1:0] c, input logic [W-1:0] t);
    exp_t e;
    e.busy = b; e.done = d; e.count = c; e.tvec = t;
    return e;
  endfunction

  function automatic void chk(input string nm, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Monitor: one snapshot per cycle while the scoreboard holds expectations.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("busy",  W'(bus.busy), W'(e.busy));
      chk("done",  W'(bus.done), W'(e.done));
      chk("count", bus.count,    e.count);
      chk("t_vec", bus.t_vec,    e.tvec);
    end
  end

  // Reference trace for one command, starting with the cycle start is raised.
  // Returns the trace index of the abort cycle, or -1 if no abort.
  function automatic int push_cmd(input logic [W-1:0] lv, input logic [W-1:0] tv,
                                  input logic u, input int abort_cnt);
    logic [W-1:0] d;
    logic [W-1:0] c;
    logic [W-1:0] t;
    int idx;
    d = u ? (tv - lv) : (lv - tv);
    sb.push_back(mk(1'b0, 1'b0, mq, '0));
    sb.push_back(mk(1'b1, 1'b0, mq, mq ^ lv));
    idx = 2;
    for (int k = 0; k <= int'(d); k++) begin
      c = u ? (lv + W'(k)) : (lv - W'(k));
      t = (k < int'(d)) ? W'(step_toggle(MAX_W'(c), W, u)) : '0;
      sb.push_back(mk(1'b1, 1'b0, c, t));
      if (abort_cnt >= 0 && int'(c) == abort_cnt) begin
        repeat (3) sb.push_back(mk(1'b0, 1'b0, '0, '0));
        mq = '0;
        return idx;
      end
      idx++;
    end
    sb.push_back(mk(1'b0, 1'b1, tv, '0));
    sb.push_back(mk(1'b0, 1'b0, tv, '0));
    mq = tv;
    return -1;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_cmd(input logic [W-1:0] lv, input logic [W-1:0] tv,
                         input logic u, input bit junk, input int abort_cnt);
    int idx;
    @(posedge clk); #1;
    bus.load_val = lv; bus.target = tv; bus.up = u; bus.start = 1'b1;
    idx = push_cmd(lv, tv, u, abort_cnt);
    @(posedge clk); #1;
    bus.start = junk;
    if (junk) begin
      bus.load_val = W'($urandom);
      bus.target   = W'($urandom);
      bus.up       = 1'($urandom);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (idx >= 0) begin
      repeat (idx - 2) begin @(posedge clk); #1; end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
    end
    drain();
  endtask

  initial begin
    clr = 1'b1;
    bus.start = 1'b1; bus.load_val = 4'd5; bus.target = 4'd9; bus.up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    bus.start = 1'b0;
    repeat (3) sb.push_back(mk(1'b0, 1'b0, '0, '0));
    mq = '0;
    drain();

    run_cmd(4'd3,  4'd7,  1'b1, 1'b0, -1);
    run_cmd(4'd1,  4'd14, 1'b0, 1'b0, -1);
    run_cmd(4'd9,  4'd9,  1'b1, 1'b1, -1);
    run_cmd(4'd2,  4'd12, 1'b1, 1'b0, 5);
    run_cmd(4'd0,  4'd15, 1'b1, 1'b0, -1);
    run_cmd(4'd0,  4'd0,  1'b0, 1'b1, -1);
    for (int i = 0; i < 10; i++)
      run_cmd(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far",
             n_pass, n_total);
    $fatal(1);
  end

endmodule
